// File: rtl/acc_pkg.sv
// Shared types for the partial-sum sequencer: command codes, FSM states, defaults.
// Optional feature macro used by the sequencer: SEQ_AUTO_CLEAR_EN.
package acc_pkg;

    localparam int DATA_W_DEFAULT = 32;

    typedef enum logic [2:0] {
        SIG_NOP       = 3'b000,
        SIG_ACC       = 3'b001,
        SIG_OUT       = 3'b010,
        SIG_CAT_START = 3'b011,
        SIG_CAT_END   = 3'b100
    } sig_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CAT,
        ST_ACC,
        ST_OUT,
        ST_CLR,
        ST_END,
        ST_DONE
    } state_t;

    // Where to go once an output (and its optional clear beat) has been issued.
    function automatic state_t next_after_out(input logic more, input logic cat_en);
        if (more) begin
            return ST_ACC;
        end
        return cat_en ? ST_END : ST_DONE;
    endfunction

endpackage

// File: rtl/psum_fifo.sv
// Synchronous FIFO buffering partial sums ahead of the sequencer FSM.
// Pushes while full and pops while empty are ignored.
module psum_fifo
    import acc_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEFAULT,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic              full,
    output logic              empty,
    output logic [DATA_W-1:0] head
);

    localparam int AW = $clog2(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [AW:0]       count_q, count_d;
    logic              do_push, do_pop;

    assign full    = (count_q == (AW+1)'(DEPTH));
    assign empty   = (count_q == '0);
    assign head    = mem_q[rd_ptr_q];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q + AW'(do_push);
        rd_ptr_d = rd_ptr_q + AW'(do_pop);
        count_d  = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

endmodule

// File: rtl/psum_sequencer.sv
// Feeds the output accumulator stage: buffers partial sums and issues the sig/data command stream.
// Optional macro SEQ_AUTO_CLEAR_EN adds a clearing ACC beat after every OUT.
module psum_sequencer
    import acc_pkg::*;
#(
    parameter int DATA_W     = DATA_W_DEFAULT,
    parameter int LEN_W      = 8,
    parameter int CNT_W      = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [LEN_W-1:0]  cfg_acc_len,
    input  logic [CNT_W-1:0]  cfg_num_out,
    input  logic              cfg_cat_en,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic [2:0]        sig,
    output logic [DATA_W-1:0] data,
    output logic              busy,
    output logic              done
);

    state_t            state_q, state_d;
    sig_t              sig_q, sig_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [LEN_W-1:0]  acc_len_q, acc_len_d;
    logic [CNT_W-1:0]  num_out_q, num_out_d;
    logic              cat_en_q, cat_en_d;
    logic [LEN_W-1:0]  beat_q, beat_d, beat_inc;
    logic [CNT_W-1:0]  out_q, out_d, out_inc;
`ifdef SEQ_AUTO_CLEAR_EN
    logic [DATA_W-1:0] shadow_q, shadow_d;
`endif

    logic              fifo_full, fifo_empty, fifo_pop;
    logic [DATA_W-1:0] fifo_head;

    psum_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (in_valid),
        .push_data (in_data),
        .pop       (fifo_pop),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .head      (fifo_head)
    );

    assign in_ready = !fifo_full;
    assign sig      = sig_q;
    assign data     = data_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign beat_inc = beat_q + LEN_W'(1);
    assign out_inc  = out_q + CNT_W'(1);

    always_comb begin
        state_d   = state_q;
        sig_d     = SIG_NOP;
        data_d    = '0;
        busy_d    = busy_q;
        done_d    = 1'b0;
        acc_len_d = acc_len_q;
        num_out_d = num_out_q;
        cat_en_d  = cat_en_q;
        beat_d    = beat_q;
        out_d     = out_q;
        fifo_pop  = 1'b0;
`ifdef SEQ_AUTO_CLEAR_EN
        shadow_d  = shadow_q;
`endif
        case (state_q)
            ST_IDLE: begin
                beat_d = '0;
                out_d  = '0;
                if (start) begin
                    acc_len_d = cfg_acc_len;
                    num_out_d = cfg_num_out;
                    cat_en_d  = cfg_cat_en;
                    busy_d    = 1'b1;
                    if (cfg_acc_len == '0 || cfg_num_out == '0) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = cfg_cat_en ? ST_CAT : ST_ACC;
                    end
                end
            end
            ST_CAT: begin
                sig_d   = SIG_CAT_START;
                state_d = ST_ACC;
            end
            ST_ACC: begin
                // An empty FIFO stalls here with NOP; no beat is counted.
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    sig_d    = SIG_ACC;
                    data_d   = fifo_head;
                    beat_d   = beat_inc;
`ifdef SEQ_AUTO_CLEAR_EN
                    shadow_d = shadow_q + fifo_head;
`endif
                    if (beat_inc == acc_len_q) begin
                        state_d = ST_OUT;
                    end
                end
            end
            ST_OUT: begin
                sig_d  = SIG_OUT;
                beat_d = '0;
                out_d  = out_inc;
`ifdef SEQ_AUTO_CLEAR_EN
                state_d = ST_CLR;
`else
                state_d = next_after_out(out_inc < num_out_q, cat_en_q);
`endif
            end
`ifdef SEQ_AUTO_CLEAR_EN
            ST_CLR: begin
                sig_d    = SIG_ACC;
                data_d   = '0 - shadow_q;
                shadow_d = '0;
                state_d  = next_after_out(out_q < num_out_q, cat_en_q);
            end
`endif
            ST_END: begin
                sig_d   = SIG_CAT_END;
                state_d = ST_DONE;
            end
            ST_DONE: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            sig_q     <= SIG_NOP;
            data_q    <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            acc_len_q <= '0;
            num_out_q <= '0;
            cat_en_q  <= 1'b0;
            beat_q    <= '0;
            out_q     <= '0;
`ifdef SEQ_AUTO_CLEAR_EN
            shadow_q  <= '0;
`endif
        end else begin
            state_q   <= state_d;
            sig_q     <= sig_d;
            data_q    <= data_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            acc_len_q <= acc_len_d;
            num_out_q <= num_out_d;
            cat_en_q  <= cat_en_d;
            beat_q    <= beat_d;
            out_q     <= out_d;
`ifdef SEQ_AUTO_CLEAR_EN
            shadow_q  <= shadow_d;
`endif
        end
    end

endmodule

// File: tb/tb_psum_sequencer.sv
// Self-checking bench for psum_sequencer: table-driven jobs, directed corner cases and random jobs
// checked against a job-level command-stream model. Honours SEQ_AUTO_CLEAR_EN if defined.
module tb_psum_sequencer;

    localparam int DW    = 32;
    localparam int LW    = 8;
    localparam int CW    = 8;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic [LW-1:0] alen = '0;
    logic [CW-1:0] nout = '0;
    logic          cat = 1'b0;
    logic          in_valid = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic          in_ready;
    logic [2:0]    sig;
    logic [DW-1:0] data;
    logic          busy, done;

    psum_sequencer #(
        .DATA_W     (DW),
        .LEN_W      (LW),
        .CNT_W      (CW),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .cfg_acc_len (alen),
        .cfg_num_out (nout),
        .cfg_cat_en  (cat),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .sig         (sig),
        .data        (data),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]    s;
        logic [DW-1:0] d;
        int            c;
    } cmd_t;

    typedef struct {
        int a;
        int n;
        int c;
        int pre;
        int gmin;
        int gmax;
        int exp_outs;
    } vec_t;

    int            checks = 0;
    int            errors = 0;
    int            cyc = 0;
    cmd_t          got[$];
    cmd_t          exp_q[$];
    logic [DW-1:0] wq[$];
    logic [DW-1:0] fixed_q[$];
    int            pushed = 0;
    int            done_cnt = 0;
    int            done_cyc = 0;
    int            nop_bad = 0;
    int            start_cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rst) begin
            if (sig != 3'b000) got.push_back('{sig, data, cyc});
            else if (data != '0) nop_bad++;
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
        end
    end

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Expected command stream of a whole job, straight from the command-stream rules.
    function automatic void build_model(input int a, input int n, input int c);
        int            k;
        logic [DW-1:0] sum;
        exp_q.delete();
        k = 0;
        if (a == 0 || n == 0) return;
        if (c != 0) exp_q.push_back('{3'b011, '0, 0});
        for (int o = 0; o < n; o++) begin
            sum = '0;
            for (int b = 0; b < a; b++) begin
                exp_q.push_back('{3'b001, wq[k], 0});
                sum = sum + wq[k];
                k++;
            end
            exp_q.push_back('{3'b010, '0, 0});
`ifdef SEQ_AUTO_CLEAR_EN
            exp_q.push_back('{3'b001, -sum, 0});
`endif
        end
        if (c != 0) exp_q.push_back('{3'b100, '0, 0});
    endfunction

    task automatic feed(input int gmin, input int gmax);
        int g;
        int tmo;
        logic ok;
        foreach (wq[i]) begin
            g = $urandom_range(gmax, gmin);
            repeat (g) begin
                in_valid = 1'b0;
                @(posedge clk); #1;
            end
            in_valid = 1'b1;
            in_data  = wq[i];
            ok = 1'b0;
            tmo = 0;
            while (!ok && tmo < 1000) begin
                @(negedge clk);
                ok = in_ready;
                @(posedge clk); #1;
                tmo++;
            end
            check("feed_handshake", {63'd0, ok}, 64'd1);
            pushed++;
        end
        in_valid = 1'b0;
    endtask

    task automatic run_job(input string nm, input int a, input int n, input int c,
                           input int pre, input int gmin, input int gmax, input int exp_outs);
        int total;
        int tmo;
        int outs;
        int m;
        wq.delete();
        total = (a == 0 || n == 0) ? 0 : a * n;
        if (fixed_q.size() > 0) wq = fixed_q;
        else for (int i = 0; i < total; i++) wq.push_back($urandom);
        build_model(a, n, c);
        got.delete();
        done_cnt = 0;
        nop_bad = 0;
        pushed = 0;
        fork
            feed(gmin, gmax);
            begin
                tmo = 0;
                while (pushed < pre && tmo < 200) begin
                    @(posedge clk); #1;
                    tmo++;
                end
                if (pre == DEPTH) begin
                    repeat (2) begin @(posedge clk); #1; end
                    @(negedge clk);
                    check({nm, " full_in_ready"}, {63'd0, in_ready}, 64'd0);
                    @(posedge clk); #1;
                end
                alen = LW'(a);
                nout = CW'(n);
                cat = c[0];
                start = 1'b1;
                @(posedge clk); #1;
                start = 1'b0;
                start_cyc = cyc;
                check({nm, " busy_after_start"}, {63'd0, busy}, 64'd1);
                if (total > 0) begin
                    alen = LW'(a + 1);
                    nout = CW'(n + 1);
                    cat = ~c[0];
                    start = 1'b1;
                    @(posedge clk); #1;
                    start = 1'b0;
                end
                tmo = 0;
                while (done_cnt == 0 && tmo < 3000) begin
                    @(posedge clk); #1;
                    tmo++;
                end
                check({nm, " done_seen"}, {63'd0, done_cnt != 0}, 64'd1);
                check({nm, " busy_after_done"}, {63'd0, busy}, 64'd0);
            end
        join
        repeat (3) begin @(posedge clk); #1; end
        check({nm, " done_pulses"}, 64'(done_cnt), 64'd1);
        check({nm, " nop_data"}, 64'(nop_bad), 64'd0);
        check({nm, " cmd_count"}, 64'(got.size()), 64'(exp_q.size()));
        m = (got.size() < exp_q.size()) ? got.size() : exp_q.size();
        outs = 0;
        for (int i = 0; i < m; i++) begin
            check($sformatf("%s sig[%0d]", nm, i), 64'(got[i].s), 64'(exp_q[i].s));
            check($sformatf("%s data[%0d]", nm, i), 64'(got[i].d), 64'(exp_q[i].d));
        end
        foreach (got[i]) if (got[i].s == 3'b010) outs++;
        check({nm, " out_beats"}, 64'(outs), 64'(exp_outs));
        if (total == 0) check({nm, " done_latency"}, 64'(done_cyc - start_cyc), 64'd1);
        fixed_q.delete();
    endtask

    vec_t vt[8];

    initial begin
        int first_out;
        int span;
        vt[0] = '{1, 1, 0, 0, 0, 0, 1};
        vt[1] = '{3, 2, 1, 4, 0, 1, 2};
        vt[2] = '{5, 3, 0, 2, 0, 2, 3};
        vt[3] = '{2, 4, 1, 0, 1, 3, 4};
        vt[4] = '{0, 3, 1, 0, 0, 0, 0};
        vt[5] = '{4, 0, 0, 0, 0, 0, 0};
        vt[6] = '{16, 2, 0, 4, 0, 1, 2};
        vt[7] = '{1, 5, 1, 1, 0, 0, 5};

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset sig", 64'(sig), 64'd0);
        check("reset data", 64'(data), 64'd0);
        check("reset busy", {63'd0, busy}, 64'd0);
        check("reset done", {63'd0, done}, 64'd0);
        check("reset in_ready", {63'd0, in_ready}, 64'd1);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;

        // Back-to-back ACC beats followed immediately by OUT.
        fixed_q = '{32'd5, 32'd7, 32'd9};
        run_job("t1", 3, 1, 0, 3, 0, 0, 1);
        if (got.size() >= 4) begin
            check("t1 acc_gap0", 64'(got[1].c - got[0].c), 64'd1);
            check("t1 acc_gap1", 64'(got[2].c - got[1].c), 64'd1);
            check("t1 out_follows", 64'(got[3].c - got[2].c), 64'd1);
        end

        fixed_q = '{32'd1, 32'd2, 32'd3, 32'd4};
        run_job("t2", 2, 2, 1, 0, 0, 0, 2);
        if (got.size() >= 2) begin
            check("t2 first_cat_start", 64'(got[0].s), 64'd3);
            check("t2 last_cat_end", 64'(got[got.size()-1].s), 64'd4);
        end

`ifdef SEQ_AUTO_CLEAR_EN
        fixed_q = '{32'd10, 32'd20};
        run_job("t3", 2, 1, 0, 0, 0, 0, 1);
        if (got.size() >= 4) check("t3 clear_data", 64'(got[3].d), 64'hFFFF_FFE2);
`endif

        // FIFO filled in IDLE before the job starts; overflow words wait on in_ready.
        run_job("t4", 3, 2, 0, DEPTH, 0, 0, 2);

        // Input gaps during ACC stretch the beat stream with NOPs.
        run_job("t5", 4, 2, 0, 0, 3, 3, 2);
        first_out = -1;
        foreach (got[i]) if (got[i].s == 3'b010 && first_out < 0) first_out = i;
        if (first_out > 0) begin
            span = got[first_out].c - got[0].c;
            check("t5 stall_span", {63'd0, span > 4}, 64'd1);
        end

        // Reset in the middle of a stalled ACC phase abandons the job.
        got.delete();
        done_cnt = 0;
        alen = 8'd4; nout = 8'd1; cat = 1'b0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wq = '{32'h11, 32'h22};
        feed(0, 0);
        repeat (4) begin @(posedge clk); #1; end
        check("t6 stalled_busy", {63'd0, busy}, 64'd1);
        in_valid = 1'b1;
        in_data = 32'h33;
        rst = 1'b0;
        @(negedge clk);
        check("t6 rst sig", 64'(sig), 64'd0);
        check("t6 rst busy", {63'd0, busy}, 64'd0);
        check("t6 rst in_ready", {63'd0, in_ready}, 64'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        rst = 1'b1;
        repeat (4) begin @(posedge clk); #1; end
        check("t6 no_done", 64'(done_cnt), 64'd0);
        check("t6 cmds_before_rst", 64'(got.size()), 64'd2);
        check("t6 busy_idle", {63'd0, busy}, 64'd0);
        run_job("t6 after", 1, 1, 0, 0, 0, 0, 1);

        foreach (vt[i]) begin
            run_job($sformatf("vec%0d", i), vt[i].a, vt[i].n, vt[i].c,
                    vt[i].pre, vt[i].gmin, vt[i].gmax, vt[i].exp_outs);
        end

        for (int r = 0; r < 6; r++) begin
            int a, n, pre;
            a = $urandom_range(6, 1);
            n = $urandom_range(4, 1);
            pre = $urandom_range(DEPTH, 0);
            if (pre > a * n) pre = a * n;
            run_job($sformatf("rnd%0d", r), a, n, $urandom_range(1, 0), pre, 0,
                    $urandom_range(2, 0), n);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        errors++;
        $display("FAIL global_timeout: got no finish expected finish");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "timeout");
    end

endmodule
